// File: rtl/adder_pkg.sv
// Shared types and defaults for the adder and its downstream result FIFO.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package adder_pkg;

  localparam int ADDER_WIDTH = 8;
  localparam int FIFO_DEPTH  = 4;
  localparam int DROP_WIDTH  = 8;

  // One adder result as stored in the FIFO: carry sits above the sum.
  typedef struct packed {
    logic                   carry;
    logic [ADDER_WIDTH-1:0] sum;
  } result_t;

  // Assemble a result record from its parts.
  function automatic result_t make_result(input logic carry, input logic [ADDER_WIDTH-1:0] sum);
    result_t r;
    r.carry = carry;
    r.sum   = sum;
    return r;
  endfunction

endpackage

// File: rtl/adder_result_fifo_if.sv
// Adder-to-FIFO write channel plus FIFO-to-consumer valid/ready channel.
// Latency: none (wiring only).
// Backpressure: Out_ready stalls the consumer side; the adder side has none.
interface adder_result_fifo_if
  import adder_pkg::*;
#(
  parameter int WIDTH = ADDER_WIDTH
) ();

  logic [WIDTH-1:0] Sum_result;
  logic             Sum_carry;
  logic             Data_ready;
  logic [WIDTH:0]   Out_data;
  logic             Out_valid;
  logic             Out_ready;

  // FIFO side: receives adder results, sources the consumer stream.
  modport master (
    input  Sum_result, Sum_carry, Data_ready, Out_ready,
    output Out_data, Out_valid
  );

  // Environment side: the adder plus the consumer.
  modport slave (
    output Sum_result, Sum_carry, Data_ready, Out_ready,
    input  Out_data, Out_valid
  );

endinterface

// File: rtl/sync_fifo_mem.sv
// DEPTH x W register array with one synchronous write port and one async read port.
// Latency: write visible on the read port the cycle after the write edge.
// Backpressure: none; the caller decides when writes are legal.
module sync_fifo_mem #(
  parameter int W     = 9,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data
);

  logic [W-1:0] mem [DEPTH];

  // Storage is not reset; validity is tracked by the owner's count.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/adder_result_fifo.sv
// Buffers adder results {carry,sum} and streams them out with valid/ready; counts drops when full.
// Latency: a result strobed at edge N is presented (Out_valid=1) in cycle N+1; no empty bypass.
// Backpressure: Out_ready low holds the head stable; the adder cannot be stalled, so overflow drops.
module adder_result_fifo
  import adder_pkg::*;
#(
  parameter int WIDTH  = ADDER_WIDTH,
  parameter int DEPTH  = FIFO_DEPTH,
  parameter int DROP_W = DROP_WIDTH,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     Clear_ovf,
  adder_result_fifo_if.master      bus,
  output logic [CNT_W-1:0]         Fifo_count,
  output logic                     Full,
  output logic                     Overflow,
  output logic [DROP_W-1:0]        Drop_count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;
  logic [WIDTH:0]    head;
  logic              push;
  logic              pop;
  logic              wr_en;
  logic              drop;

  // Full/empty come from the count, so pointer equality never needs disambiguating.
  assign push          = bus.Data_ready;
  assign Full          = (count == CNT_W'(DEPTH));
  assign bus.Out_valid = (count != '0);
  assign pop           = bus.Out_valid & bus.Out_ready;
  assign wr_en         = push & (!Full | pop);
  assign drop          = push & Full & !pop;
  assign Fifo_count    = count;

  // Head is masked while empty so the output reads zero after reset regardless of storage.
  assign bus.Out_data  = bus.Out_valid ? head : '0;

  sync_fifo_mem #(
    .W     (WIDTH + 1),
    .DEPTH (DEPTH),
    .AW    (PTR_W)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_en & !reset),
    .wr_addr (wr_ptr),
    .wr_data ({bus.Sum_carry, bus.Sum_result}),
    .rd_addr (rd_ptr),
    .rd_data (head)
  );

  // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)   rd_ptr <= rd_ptr + PTR_W'(1);
      case ({wr_en, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky overflow and saturating drop counter; a drop in the same cycle as a clear wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      Overflow   <= 1'b0;
      Drop_count <= '0;
    end else if (drop) begin
      Overflow <= 1'b1;
      if (Clear_ovf)
        Drop_count <= DROP_W'(1);
      else if (Drop_count != '1)
        Drop_count <= Drop_count + DROP_W'(1);
    end else if (Clear_ovf) begin
      Overflow   <= 1'b0;
      Drop_count <= '0;
    end
  end

endmodule

// File: tb/tb_adder_result_fifo.sv
// Directed bench with a queue-based reference model of the result FIFO.
// Outputs are checked at every falling edge against the model before new inputs are applied.
module tb_adder_result_fifo;
  import adder_pkg::*;

  localparam int W  = 8;
  localparam int D  = 4;
  localparam int CW = $clog2(D + 1);

  logic            clk = 1'b0;
  logic            reset;
  logic            clear_ovf;
  logic [CW-1:0]   fifo_count;
  logic            full;
  logic            overflow;
  logic [7:0]      drop_count;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  logic [W:0] mq[$];
  logic       m_ovf;
  int         m_drop;

  adder_result_fifo_if #(.WIDTH(W)) bus ();

  adder_result_fifo #(
    .WIDTH  (W),
    .DEPTH  (D),
    .DROP_W (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .Clear_ovf  (clear_ovf),
    .bus        (bus),
    .Fifo_count (fifo_count),
    .Full       (full),
    .Overflow   (overflow),
    .Drop_count (drop_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare every observable output against the model.
  task automatic check_state(input string tag);
    logic [W:0] exp_head;
    exp_head = (mq.size() != 0) ? mq[0] : '0;
    chk({tag, ".count"},    32'(fifo_count),     32'(mq.size()));
    chk({tag, ".valid"},    32'(bus.Out_valid),  32'(mq.size() != 0));
    chk({tag, ".full"},     32'(full),           32'(mq.size() == D));
    chk({tag, ".data"},     32'(bus.Out_data),   32'(exp_head));
    chk({tag, ".ovf"},      32'(overflow),       32'(m_ovf));
    chk({tag, ".drops"},    32'(drop_count),     32'(m_drop));
  endtask

  // One clock: check outputs, drive inputs, advance the model, take the edge.
  task automatic step(input string tag, input logic dr, input logic carry, input logic [W-1:0] sum,
                      input logic rdy, input logic clr, input logic rst);
    logic pop_m;
    logic full_m;
    @(negedge clk);
    check_state(tag);
    bus.Data_ready = dr;
    bus.Sum_carry  = carry;
    bus.Sum_result = sum;
    bus.Out_ready  = rdy;
    clear_ovf      = clr;
    reset          = rst;
    pop_m  = (mq.size() != 0) && rdy;
    full_m = (mq.size() == D);
    if (rst) begin
      mq.delete();
      m_ovf  = 1'b0;
      m_drop = 0;
    end else begin
      if (dr && full_m && !pop_m) begin
        m_ovf  = 1'b1;
        m_drop = clr ? 1 : ((m_drop == 255) ? 255 : m_drop + 1);
      end else if (clr) begin
        m_ovf  = 1'b0;
        m_drop = 0;
      end
      if (pop_m) void'(mq.pop_front());
      if (dr && (!full_m || pop_m)) mq.push_back(make_result(carry, sum));
    end
    @(posedge clk);
  endtask

  task automatic idle(input string tag, input logic rdy);
    step(tag, 1'b0, 1'b0, 8'h00, rdy, 1'b0, 1'b0);
  endtask

  task automatic push(input string tag, input logic [W-1:0] sum, input logic rdy);
    step(tag, 1'b1, 1'b0, sum, rdy, 1'b0, 1'b0);
  endtask

  initial begin
    bus.Data_ready = 1'b0;
    bus.Sum_carry  = 1'b0;
    bus.Sum_result = '0;
    bus.Out_ready  = 1'b0;
    clear_ovf      = 1'b0;
    reset          = 1'b1;
    m_ovf          = 1'b0;
    m_drop         = 0;
    repeat (2) @(posedge clk);

    // Reset state, then single push with carry and pop.
    step("rst", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    step("single_push", 1'b1, 1'b1, 8'h2A, 1'b0, 1'b0, 1'b0);
    idle("single_hold", 1'b0);
    idle("single_pop", 1'b1);
    idle("single_empty", 1'b0);

    // Fill to full with consumer stalled, then drain in order.
    for (int i = 1; i <= 4; i++) push("fill", 8'(i), 1'b0);
    idle("full_hold", 1'b0);
    for (int i = 0; i < 5; i++) idle("drain", 1'b1);

    // Empty push with ready: pop ignored, write accepted.
    push("empty_pushpop", 8'h77, 1'b1);
    idle("empty_pushpop_pop", 1'b1);

    // Drop while full, then push+pop while full is accepted.
    for (int i = 1; i <= 4; i++) push("refill", 8'(i), 1'b0);
    push("drop", 8'h05, 1'b0);
    push("full_pushpop", 8'h06, 1'b1);
    for (int i = 0; i < 5; i++) idle("drain2", 1'b1);
    step("clear", 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

    // Steady streaming at count 2 across several pointer wraps.
    push("pre1", 8'h10, 1'b0);
    push("pre2", 8'h11, 1'b0);
    for (int i = 0; i < 10; i++) push("stream", 8'(8'h20 + i), 1'b1);
    for (int i = 0; i < 3; i++) idle("drain3", 1'b1);

    // Drop counter saturation and clear interaction.
    for (int i = 1; i <= 4; i++) push("fill4", 8'(8'h40 + i), 1'b0);
    for (int i = 0; i < 300; i++) push("sat", 8'(i), 1'b0);
    step("clr_drop", 1'b1, 1'b0, 8'hEE, 1'b0, 1'b1, 1'b0);
    step("clr_only", 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    idle("after_clr", 1'b0);

    // Reset mid-stream with a push pending.
    idle("to3", 1'b1);
    push("drop_again", 8'h99, 1'b0);
    push("drop_again2", 8'h98, 1'b0);
    idle("pre_rst", 1'b1);
    step("rst_push", 1'b1, 1'b1, 8'h55, 1'b0, 1'b0, 1'b1);
    step("post_rst", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    idle("post_rst2", 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
